// File: rtl/cmos_seq_pkg.sv
// Shared types and default 27 MHz timing for the OV5640 power-up sequencer.
package cmos_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK   = 3'd0,
    ST_LOCK_SETTLE = 3'd1,
    ST_PWDN        = 3'd2,
    ST_RESET       = 3'd3,
    ST_BOOT        = 3'd4,
    ST_CFG         = 3'd5,
    ST_READY       = 3'd6,
    ST_FAULT       = 3'd7
  } seq_state_e;

  localparam int unsigned DEF_CNT_W           = 20;
  localparam int unsigned DEF_LOCK_CYC        = 2700;
  localparam int unsigned DEF_PWDN_CYC        = 27000;
  localparam int unsigned DEF_RST_CYC         = 27000;
  localparam int unsigned DEF_BOOT_CYC        = 540000;
  localparam int unsigned DEF_CFG_TIMEOUT_CYC = 1000000;
  localparam int unsigned DEF_MAX_RETRY       = 3;

  typedef struct packed {
    logic xclk_en;
    logic cmos_pwdn;
    logic cmos_rst_n;
  } sensor_pins_t;

  // Sensor pin levels held while the sequencer sits in a given state.
  function automatic sensor_pins_t pins_for(seq_state_e s);
    sensor_pins_t p;
    p = '{xclk_en: 1'b0, cmos_pwdn: 1'b1, cmos_rst_n: 1'b0};
    case (s)
      ST_PWDN:  p = '{xclk_en: 1'b1, cmos_pwdn: 1'b1, cmos_rst_n: 1'b0};
      ST_RESET: p = '{xclk_en: 1'b1, cmos_pwdn: 1'b0, cmos_rst_n: 1'b0};
      ST_BOOT,
      ST_CFG,
      ST_READY: p = '{xclk_en: 1'b1, cmos_pwdn: 1'b0, cmos_rst_n: 1'b1};
      default:  p = '{xclk_en: 1'b0, cmos_pwdn: 1'b1, cmos_rst_n: 1'b0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cmos_seq_timer.sv
// Up-counter with synchronous clear; tc_c flags the cycle where cnt equals term.
module cmos_seq_timer
  import cmos_seq_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == term);

endmodule

// File: rtl/cmos_power_seq.sv
// OV5640 power-up/reset sequencer: PLL lock -> XCLK -> PWDN/RESETB release -> SCCB config, with retry.
module cmos_power_seq
  import cmos_seq_pkg::*;
#(
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned LOCK_CYC        = DEF_LOCK_CYC,
  parameter int unsigned PWDN_CYC        = DEF_PWDN_CYC,
  parameter int unsigned RST_CYC         = DEF_RST_CYC,
  parameter int unsigned BOOT_CYC        = DEF_BOOT_CYC,
  parameter int unsigned CFG_TIMEOUT_CYC = DEF_CFG_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               cfg_done,
  input  logic               cfg_err,
  output logic               xclk_en,
  output logic               cmos_pwdn,
  output logic               cmos_rst_n,
  output logic               cfg_start,
  output logic               cam_ready,
  output logic               seq_err,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

  if (64'(LOCK_CYC) >= CNT_LIMIT || 64'(PWDN_CYC) >= CNT_LIMIT || 64'(RST_CYC) >= CNT_LIMIT ||
      64'(BOOT_CYC) >= CNT_LIMIT || 64'(CFG_TIMEOUT_CYC) >= CNT_LIMIT) begin : g_bad_width
    $error("cmos_power_seq: a *_CYC parameter does not fit in CNT_W bits");
  end
  if (LOCK_CYC == 0 || PWDN_CYC == 0 || RST_CYC == 0 || BOOT_CYC == 0 ||
      CFG_TIMEOUT_CYC == 0) begin : g_bad_zero
    $error("cmos_power_seq: *_CYC parameters must be at least 1");
  end

  // PLL lock arrives from another clock source; two flops before use.
  logic [1:0] lock_sync;
  logic       lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
    end
  end

  assign lock_s = lock_sync[1];

  seq_state_e         state;
  seq_state_e         next_state;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_next;
  logic [CNT_W-1:0]   term;
  logic               tc_c;
  sensor_pins_t       pins_next;

  cmos_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (next_state != state),
    .term  (term),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT_LOCK;
      retry_cnt <= '0;
    end else begin
      state     <= next_state;
      retry_cnt <= retry_next;
    end
  end

  // Next state, retry bookkeeping and per-state terminal count.
  always_comb begin
    next_state = state;
    retry_next = retry_cnt;
    term       = '0;
    case (state)
      ST_WAIT_LOCK: begin
        if (lock_s) next_state = ST_LOCK_SETTLE;
      end
      ST_LOCK_SETTLE: begin
        term = CNT_W'(LOCK_CYC - 1);
        if (tc_c) next_state = ST_PWDN;
      end
      ST_PWDN: begin
        term = CNT_W'(PWDN_CYC - 1);
        if (tc_c) next_state = ST_RESET;
      end
      ST_RESET: begin
        term = CNT_W'(RST_CYC - 1);
        if (tc_c) next_state = ST_BOOT;
      end
      ST_BOOT: begin
        term = CNT_W'(BOOT_CYC - 1);
        if (tc_c) next_state = ST_CFG;
      end
      ST_CFG: begin
        term = CNT_W'(CFG_TIMEOUT_CYC - 1);
        if (cfg_err || tc_c) begin
          if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
            retry_next = retry_cnt + RETRY_W'(1);
            next_state = ST_RESET;
          end else begin
            next_state = ST_FAULT;
          end
        end else if (cfg_done) begin
          next_state = ST_READY;
        end
      end
      default: begin
      end
    endcase
    // Losing lock overrides everything except the parked states.
    if (!lock_s && state != ST_WAIT_LOCK && state != ST_FAULT) begin
      next_state = ST_WAIT_LOCK;
    end
    if (next_state == ST_WAIT_LOCK) begin
      retry_next = '0;
    end
  end

  assign pins_next = pins_for(next_state);

  // Outputs decoded from next_state so they move with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xclk_en    <= 1'b0;
      cmos_pwdn  <= 1'b1;
      cmos_rst_n <= 1'b0;
      cfg_start  <= 1'b0;
      cam_ready  <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      xclk_en    <= pins_next.xclk_en;
      cmos_pwdn  <= pins_next.cmos_pwdn;
      cmos_rst_n <= pins_next.cmos_rst_n;
      cfg_start  <= (next_state == ST_CFG) && (state != ST_CFG);
      cam_ready  <= (next_state == ST_READY);
      seq_err    <= (next_state == ST_FAULT);
    end
  end

  assign state_o = state;

endmodule
